// File: rtl/sram_fifo_ctrl_256_32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_fifo_ctrl_256_32                                         |
// | Brief    : valid/ready FIFO over a 1R1W SRAM with a 2-entry prefetch     |
// |            output buffer; optional high-water mark (SRAM_FIFO_STATS_EN). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sram_fifo_ctrl_256_32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] sram_wadr,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_radr,
    output logic                  sram_re,
    input  logic [DATA_WIDTH-1:0] sram_q
`ifdef SRAM_FIFO_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   hwm
`endif
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  r_inflight;
    logic [1:0]            r_obuf_cnt;
    logic [DATA_WIDTH-1:0] r_obuf0;
    logic [DATA_WIDTH-1:0] r_obuf1;
    logic                  w_flush;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_prefetch;
    logic [2:0]            w_slots;

    assign w_flush   = rst | clear;
    assign in_ready  = ~w_flush & (r_count < c_DEPTH);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = ~w_flush & (r_obuf_cnt != 2'd0);
    assign out_data  = r_obuf0;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    // Buffer slots committed after this cycle; crediting the pop keeps one
    // read issued every cycle in steady state.
    assign w_slots    = {1'b0, r_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_prefetch = ~w_flush & (r_wptr != r_rptr) & (w_slots < 3'd2);

    assign sram_we   = w_accept;
    assign sram_wadr = r_wptr[ADDR_WIDTH-1:0];
    assign sram_d    = in_data;
    assign sram_re   = w_prefetch;
    assign sram_radr = r_rptr[ADDR_WIDTH-1:0];

    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop) begin
            w_count_nxt = r_count + c_PTR_ONE;
        end else if (!w_accept && w_pop) begin
            w_count_nxt = r_count - c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_obuf_cnt <= 2'd0;
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= w_prefetch;
            if (w_accept) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_prefetch) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            // sram_q is only meaningful while a read is in flight
            case ({r_inflight, w_pop})
                2'b01: begin
                    r_obuf0    <= r_obuf1;
                    r_obuf_cnt <= r_obuf_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_obuf_cnt == 2'd0) begin
                        r_obuf0 <= sram_q;
                    end else begin
                        r_obuf1 <= sram_q;
                    end
                    r_obuf_cnt <= r_obuf_cnt + 2'd1;
                end
                2'b11: begin
                    if (r_obuf_cnt == 2'd1) begin
                        r_obuf0 <= sram_q;
                    end else begin
                        r_obuf0 <= r_obuf1;
                        r_obuf1 <= sram_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SRAM_FIFO_STATS_EN
    logic [ADDR_WIDTH:0] r_hwm;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_hwm <= '0;
        end else if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign hwm = r_hwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl_256_32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_fifo_ctrl_256_32                                      |
// | Brief    : scoreboard bench for sram_fifo_ctrl_256_32 with an SRAM model.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sram_fifo_ctrl_256_32;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   count;
    logic [AW-1:0] sram_wadr;
    logic [DW-1:0] sram_d;
    logic          sram_we;
    logic [AW-1:0] sram_radr;
    logic          sram_re;
    logic [DW-1:0] sram_q;
`ifdef SRAM_FIFO_STATS_EN
    logic [AW:0]   hwm;
`endif

    always #5 clk = ~clk;

    sram_fifo_ctrl_256_32 dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .sram_wadr (sram_wadr),
        .sram_d    (sram_d),
        .sram_we   (sram_we),
        .sram_radr (sram_radr),
        .sram_re   (sram_re),
        .sram_q    (sram_q)
`ifdef SRAM_FIFO_STATS_EN
        ,
        .hwm       (hwm)
`endif
    );

    // SRAM wrapper model: one-cycle read, garbage on q when no read was issued
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (sram_we) mem[sram_wadr] <= sram_d;
        sram_q <= sram_re ? mem[sram_radr] : $urandom;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of words held, an occupancy count and a write index
    logic [DW-1:0] exp_q[$];
    int            m_held = 0;
    int            m_hwm = 0;
    logic [AW-1:0] m_wptr = '0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            n_pops = 0;
    int            last_pop_cyc = 0;
    int            n_acc = 0;

    always @(negedge clk) begin
        logic [DW-1:0] e;
        bit acc;
        bit pop;
        if (rst || clear) begin
            if (rst)
                chk(!in_ready && !out_valid && !sram_we && !sram_re, "rst_quiet",
                    64'({in_ready, out_valid, sram_we, sram_re}), 64'd0);
            else
                chk(!sram_we && !in_ready, "clear_no_accept", 64'({sram_we, in_ready}), 64'd0);
            exp_q.delete();
            m_held = 0;
            m_hwm = 0;
            m_wptr = '0;
            prev_stall = 1'b0;
        end else begin
            acc = in_valid && (m_held < DEPTH);
            pop = out_valid && out_ready;
            chk(int'(count) == m_held, "count", 64'(count), 64'(m_held));
            chk(in_ready == (m_held < DEPTH), "in_ready", 64'(in_ready), 64'(m_held < DEPTH));
            chk(sram_we == acc, "we_iff_accept", 64'(sram_we), 64'(acc));
            if (sram_we)
                chk(sram_wadr == m_wptr && sram_d == in_data, "write_port",
                    {24'd0, sram_wadr, sram_d}, {24'd0, m_wptr, in_data});
            if (sram_re && sram_we)
                chk(sram_radr != sram_wadr, "rw_same_addr", 64'(sram_radr), 64'(sram_wadr));
            if (prev_stall)
                chk(out_valid && out_data == prev_data, "stall_stable", 64'(out_data), 64'(prev_data));
`ifdef SRAM_FIFO_STATS_EN
            chk(int'(hwm) == m_hwm, "hwm", 64'(hwm), 64'(m_hwm));
`endif
            if (pop) begin
                chk(exp_q.size() != 0, "output_underflow", 64'(out_data), 64'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(out_data == e, "out_data", 64'(out_data), 64'(e));
                end
                n_pops++;
                last_pop_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            m_held = m_held + int'(acc) - int'(pop);
            if (acc) m_wptr = m_wptr + 8'd1;
            if (m_held > m_hwm) m_hwm = m_held;
        end
    end

    bit drv_rst = 1'b1;

    // One clock cycle of stimulus; returns at the falling edge of that cycle
    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit clr);
        @(posedge clk);
        #1;
        rst = drv_rst;
        clear = clr;
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        @(negedge clk);
        if (in_valid && in_ready && !rst && !clear) begin
            exp_q.push_back(in_data);
            n_acc++;
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int first_ov;
        int p0;
        // Reset for three cycles, then the first free cycle
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        drv_rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        chk(!out_valid && count == 9'd0 && in_ready, "post_reset",
            64'({out_valid, count, in_ready}), 64'({1'b0, 9'd0, 1'b1}));

        // Single word latency
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        c0 = cyc;
        chk(sram_we && sram_wadr == 8'd0 && sram_d == 32'hDEADBEEF, "first_write",
            {23'd0, sram_we, sram_wadr, sram_d}, {23'd0, 1'b1, 8'd0, 32'hDEADBEEF});
        first_ov = -1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (out_valid && first_ov < 0) begin
                first_ov = cyc;
                chk(out_data == 32'hDEADBEEF, "first_word", 64'(out_data), 64'hDEADBEEF);
            end
        end
        chk(first_ov - c0 == 3, "first_latency", 64'(first_ov - c0), 64'd3);
        chk(count == 9'd0, "count_back_to_zero", 64'(count), 64'd0);

        // Fill to capacity with the consumer stalled, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        repeat (4) step(1'b1, 32'd256, 1'b0, 1'b0);
        chk(!in_ready && count == 9'd256, "full_hold", 64'({in_ready, count}), 64'({1'b0, 9'd256}));
        drain(600);

        // Streaming: one word per cycle after the fill latency
        p0 = n_pops;
        c0 = cyc + 1;
        for (int i = 0; i < 1000; i++) step(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
        drain(50);
        chk(n_pops - p0 == 1000, "stream_words", 64'(n_pops - p0), 64'd1000);
        chk(last_pop_cyc - c0 == 1002, "stream_no_gaps", 64'(last_pop_cyc - c0), 64'd1002);

        // Random traffic
        n_acc = 0;
        for (int k = 0; k < 60000 && n_acc < 10000; k++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        chk(n_acc >= 10000, "random_budget", 64'(n_acc), 64'd10000);
        drain(2000);

        // Clear with a read in flight and five words held
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hA5, 1'b1, 1'b0);
        chk(sram_re, "read_before_clear", 64'(sram_re), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk(count == 9'd5, "count_before_clear", 64'(count), 64'd5);
`ifdef SRAM_FIFO_STATS_EN
        chk(hwm == 9'd5, "hwm_before_clear", 64'(hwm), 64'd5);
`endif
        step(1'b0, '0, 1'b0, 1'b0);
        chk(!out_valid && count == 9'd0, "after_clear", 64'({out_valid, count}), 64'd0);
`ifdef SRAM_FIFO_STATS_EN
        chk(hwm == 9'd0, "hwm_after_clear", 64'(hwm), 64'd0);
`endif
        for (int i = 0; i < 8; i++) step(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
